// File: rtl/kw11p_clock.sv
// rtl/kw11p_clock.sv - programmable real-time clock with Wishbone registers and vectored interrupt
//
// Purpose: CNT_W-bit counter clocked from a prescaled rate (100 kHz, 10 kHz,
// 50 Hz line or external tick) that raises a vectored interrupt when it
// reaches its terminal count. Registers: CSR (word 0), CSB (word 1, write-only),
// CTR (word 2, read-only).
//
// Optional feature macro: KW11P_EXT_EN (RATE=3 counts ext_tick rising edges;
// when undefined RATE=3 produces no count events).
//
// Ports:
//   clk_p            system clock
//   dclo             asynchronous active-high reset (also clears the prescaler)
//   init             synchronous bus reset (prescaler keeps running)
//   wb_cyc_i/stb_i   Wishbone cycle / decoded strobe
//   wb_we_i          write enable
//   wb_adr_i[1:0]    word select
//   wb_sel_i[1:0]    byte lanes
//   wb_dat_i[15:0]   write data
//   wb_dat_o[15:0]   read data (0 when not strobed)
//   wb_ack_o         transfer acknowledge
//   ext_tick         external count source (synchronous)
//   irq_o            interrupt request
//   istb_i           vector strobe from priority logic
//   ivec_o[8:0]      vector while istb_i is high
//   iack_o           vector acknowledge pulse
module kw11p_clock #(
   parameter int         CLKREF = 50000000,
   parameter int         CNT_W  = 16,
   parameter logic [8:0] VECTOR = 9'o104
) (
   input  logic        clk_p,
   input  logic        dclo,
   input  logic        init,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic        ext_tick,
   output logic        irq_o,
   input  logic        istb_i,
   output logic [8:0]  ivec_o,
   output logic        iack_o
);

   // Prescaler: a single divider chain of base /P100, then /10, then /200.
   localparam int P100 = CLKREF / 100000;
   localparam int PW   = (P100 > 1) ? $clog2(P100) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(P100 - 1);

   logic [PW-1:0]    r_pre;
   logic [3:0]       r_dec;
   logic [7:0]       r_lin;
   logic             w_s100, w_s10, w_s50;

   // Register state
   logic             r_run, r_mode, r_up, r_ie, r_done, r_err;
   logic [1:0]       r_rate;
   logic [CNT_W-1:0] r_csb, r_ctr;
   logic             r_irq, r_irq_d, r_iack;

   // Decode / datapath wires
   logic             w_req, w_xfer, w_csr_wr, w_csb_wr, w_csr_rd;
   logic             w_fix, w_ie_clr, w_sel_strobe, w_evt, w_term, w_done_evt;
   logic             w_irq_cond, w_iack_set, w_ext_edge;
   logic [CNT_W-1:0] w_ctr_next;
   logic [15:0]      w_csr, w_ctr16, w_csb16, w_csb_new, w_rdata;

   assign w_s100 = (r_pre == P_MAX);
   assign w_s10  = w_s100 & (r_dec == 4'd9);
   assign w_s50  = w_s10 & (r_lin == 8'd199);

   // Free-running; only dclo resets it, never init or register writes.
   always_ff @(posedge clk_p or posedge dclo) begin
      if (dclo) begin
         r_pre <= '0;
         r_dec <= '0;
         r_lin <= '0;
      end else begin
         r_pre <= w_s100 ? '0 : r_pre + 1'b1;
         if (w_s100) r_dec <= w_s10 ? 4'd0 : r_dec + 4'd1;
         if (w_s10)  r_lin <= w_s50 ? 8'd0 : r_lin + 8'd1;
      end
   end

`ifdef KW11P_EXT_EN
   logic r_ext_q, r_ext_d;
   // ext_tick registered once; the rising edge is seen one cycle later.
   always_ff @(posedge clk_p or posedge dclo) begin
      if (dclo) begin
         r_ext_q <= 1'b0;
         r_ext_d <= 1'b0;
      end else if (init) begin
         r_ext_q <= 1'b0;
         r_ext_d <= 1'b0;
      end else begin
         r_ext_q <= ext_tick;
         r_ext_d <= r_ext_q;
      end
   end
   assign w_ext_edge = r_ext_q & ~r_ext_d;
`else
   logic w_unused_ext;
   assign w_unused_ext = ext_tick;
   assign w_ext_edge   = 1'b0;
`endif

   // Bus decode: side effects only in the ack cycle so each access acts once.
   assign w_req    = wb_cyc_i & wb_stb_i;
   assign w_xfer   = w_req & wb_ack_o;
   assign w_csr_wr = w_xfer & wb_we_i & (wb_adr_i == 2'd0);
   assign w_csb_wr = w_xfer & wb_we_i & (wb_adr_i == 2'd1);
   assign w_csr_rd = w_xfer & ~wb_we_i & (wb_adr_i == 2'd0);
   assign w_fix    = w_csr_wr & wb_sel_i[0] & wb_dat_i[5];
   assign w_ie_clr = w_csr_wr & wb_sel_i[0] & ~wb_dat_i[6];

   assign w_csr = {r_err, 7'b0, r_done, r_ie, 1'b0, r_up, r_mode, r_rate, r_run};

   always_comb begin
      w_ctr16 = '0;
      w_ctr16[CNT_W-1:0] = r_ctr;
      w_csb16 = '0;
      w_csb16[CNT_W-1:0] = r_csb;
      w_csb_new = w_csb16;
      if (wb_sel_i[0]) w_csb_new[7:0]  = wb_dat_i[7:0];
      if (wb_sel_i[1]) w_csb_new[15:8] = wb_dat_i[15:8];
      case (wb_adr_i)
         2'd0:    w_rdata = w_csr;
         2'd2:    w_rdata = w_ctr16;
         default: w_rdata = '0;
      endcase
   end

   // Count event logic always uses the configuration held before this edge.
   always_comb begin
      case (r_rate)
         2'd0:    w_sel_strobe = w_s100;
         2'd1:    w_sel_strobe = w_s10;
         2'd2:    w_sel_strobe = w_s50;
         default: w_sel_strobe = w_ext_edge;
      endcase
   end

   assign w_evt      = (r_run & w_sel_strobe) | w_fix;
   assign w_term     = r_up ? (&r_ctr) : ((r_ctr == '0) | (r_ctr == CNT_W'(1)));
   assign w_done_evt = w_evt & w_term;

   always_comb begin
      if (w_done_evt)
         w_ctr_next = r_mode ? r_csb : '0;
      else if (r_up)
         w_ctr_next = r_ctr + 1'b1;
      else
         w_ctr_next = r_ctr - 1'b1;
   end

   always_ff @(posedge clk_p or posedge dclo) begin
      if (dclo) begin
         r_run  <= 1'b0;
         r_rate <= '0;
         r_mode <= 1'b0;
         r_up   <= 1'b0;
         r_ie   <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_csb  <= '0;
         r_ctr  <= '0;
      end else if (init) begin
         r_run  <= 1'b0;
         r_rate <= '0;
         r_mode <= 1'b0;
         r_up   <= 1'b0;
         r_ie   <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_csb  <= '0;
         r_ctr  <= '0;
      end else begin
         // A CSB load overrides any coincident count event.
         if (w_csb_wr) begin
            r_csb <= w_csb_new[CNT_W-1:0];
            r_ctr <= w_csb_new[CNT_W-1:0];
         end else if (w_evt) begin
            r_ctr <= w_ctr_next;
         end

         if (w_csr_wr && wb_sel_i[0]) begin
            r_run  <= wb_dat_i[0];
            r_rate <= wb_dat_i[2:1];
            r_mode <= wb_dat_i[3];
            r_up   <= wb_dat_i[4];
            r_ie   <= wb_dat_i[6];
         end else if (w_done_evt && !r_mode) begin
            r_run  <= 1'b0;
         end

         // A terminal event in the read-clear cycle keeps DONE set.
         if (w_done_evt)    r_done <= 1'b1;
         else if (w_csr_rd) r_done <= 1'b0;

         if (w_done_evt && r_done) r_err <= 1'b1;
         else if (w_csr_rd)        r_err <= 1'b0;
      end
   end

   // Interrupt: request on the rising edge of DONE&IE.
   assign w_irq_cond = r_done & r_ie;
   assign w_iack_set = istb_i & r_irq & ~r_iack;

   always_ff @(posedge clk_p or posedge dclo) begin
      if (dclo) begin
         r_irq    <= 1'b0;
         r_irq_d  <= 1'b0;
         r_iack   <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else if (init) begin
         r_irq    <= 1'b0;
         r_irq_d  <= 1'b0;
         r_iack   <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         r_irq_d <= w_irq_cond;
         if (w_ie_clr)                     r_irq <= 1'b0;
         else if (w_irq_cond && !r_irq_d)  r_irq <= 1'b1;
         else if (w_iack_set)              r_irq <= 1'b0;
         r_iack   <= w_iack_set;
         wb_ack_o <= w_req & ~wb_ack_o;
         wb_dat_o <= (w_req & ~wb_ack_o) ? w_rdata : 16'h0000;
      end
   end

   assign irq_o  = r_irq;
   assign iack_o = r_iack;
   assign ivec_o = istb_i ? VECTOR : 9'd0;

endmodule

// File: tb/tb_kw11p_clock.sv
// tb/tb_kw11p_clock.sv - directed self-checking bench for kw11p_clock
module tb_kw11p_clock;

   logic        clk_p = 1'b0;
   logic        dclo = 1'b1;
   logic        init = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [1:0]  wb_adr_i = '0, wb_sel_i = '0;
   logic [15:0] wb_dat_i = '0;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic        ext_tick = 1'b0;
   logic        irq_o;
   logic        istb_i = 1'b0;
   logic [8:0]  ivec_o;
   logic        iack_o;

   int errors = 0;
   int checks = 0;

   kw11p_clock #(.CLKREF(100000), .CNT_W(8), .VECTOR(9'o104)) dut (
      .clk_p(clk_p), .dclo(dclo), .init(init),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .ext_tick(ext_tick), .irq_o(irq_o), .istb_i(istb_i),
      .ivec_o(ivec_o), .iack_o(iack_o)
   );

   always #5 clk_p = ~clk_p;

   task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk_p);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = a; wb_dat_i = d; wb_sel_i = 2'b11;
      @(posedge clk_p);
      @(posedge clk_p);
      #1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk_p);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = a; wb_sel_i = 2'b11;
      @(posedge clk_p);
      @(negedge clk_p);
      d = wb_dat_o;
      @(posedge clk_p);
      #1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   task automatic wait_irq(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk_p);
         if (irq_o) break;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      repeat (3) @(posedge clk_p);
      #1;
      checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", wb_ack_o); end
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
      checks++; if (wb_dat_o !== 16'h0) begin errors++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
      @(negedge clk_p); dclo = 1'b0;
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL reset_csr got %o want 0", d); end
      wb_read(2'd2, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL reset_ctr got %o want 0", d); end
   endtask

   task automatic test_single_down();
      logic [15:0] d;
      wb_write(2'd1, 16'd5);
      wb_read(2'd2, d);
      checks++; if (d !== 16'd5) begin errors++; $display("FAIL sd_ctr_load got %0d want 5", d); end
      wb_write(2'd0, 16'o0103);
      wait_irq(200);
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL sd_irq got %b want 1", irq_o); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0302) begin errors++; $display("FAIL sd_csr got %o want 0302", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0102) begin errors++; $display("FAIL sd_csr_clr got %o want 0102", d); end
      wb_read(2'd2, d);
      checks++; if (d !== 16'd0) begin errors++; $display("FAIL sd_ctr_end got %0d want 0", d); end
   endtask

   task automatic test_irq_handshake();
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL ih_pending got %b want 1", irq_o); end
      @(negedge clk_p); istb_i = 1'b1; #1;
      checks++; if (ivec_o !== 9'o104) begin errors++; $display("FAIL ih_vec got %o want 104", ivec_o); end
      @(posedge clk_p); #1;
      checks++; if (iack_o !== 1'b1) begin errors++; $display("FAIL ih_iack got %b want 1", iack_o); end
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL ih_irq_clr got %b want 0", irq_o); end
      @(posedge clk_p); #1;
      checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL ih_iack_pulse got %b want 0", iack_o); end
      @(negedge clk_p); istb_i = 1'b0; #1;
      checks++; if (ivec_o !== 9'd0) begin errors++; $display("FAIL ih_vec_idle got %o want 0", ivec_o); end
      repeat (5) @(posedge clk_p);
      #1;
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL ih_no_rereq got %b want 0", irq_o); end
   endtask

   task automatic test_fix();
      logic [15:0] d;
      wb_write(2'd0, 16'o0);
      wb_write(2'd1, 16'd3);
      wb_write(2'd0, 16'o0040);
      wb_read(2'd2, d);
      checks++; if (d !== 16'd2) begin errors++; $display("FAIL fix_ctr1 got %0d want 2", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL fix_reads0 got %o want 0", d); end
      wb_write(2'd0, 16'o0040);
      wb_read(2'd2, d);
      checks++; if (d !== 16'd1) begin errors++; $display("FAIL fix_ctr2 got %0d want 1", d); end
      wb_write(2'd0, 16'o0040);
      wb_read(2'd2, d);
      checks++; if (d !== 16'd0) begin errors++; $display("FAIL fix_ctr3 got %0d want 0", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0200) begin errors++; $display("FAIL fix_done got %o want 0200", d); end
   endtask

   task automatic test_repeat();
      logic [15:0] d;
      logic [15:0] exp_seq [6];
      exp_seq = '{16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3};
      wb_write(2'd1, 16'd3);
      wb_write(2'd0, 16'o0010);
      for (int i = 0; i < 6; i++) begin
         wb_write(2'd0, 16'o0050);
         wb_read(2'd2, d);
         checks++; if (d !== exp_seq[i]) begin errors++; $display("FAIL rep_ctr[%0d] got %0d want %0d", i, d, exp_seq[i]); end
      end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o100210) begin errors++; $display("FAIL rep_err got %o want 100210", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0010) begin errors++; $display("FAIL rep_clr got %o want 0010", d); end
   endtask

   task automatic test_up_wrap();
      logic [15:0] d;
      wb_write(2'd1, 16'h00FE);
      wb_write(2'd0, 16'o0020);
      wb_write(2'd0, 16'o0060);
      wb_read(2'd2, d);
      checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL up_ff got %h want 00ff", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0020) begin errors++; $display("FAIL up_nodone got %o want 0020", d); end
      wb_write(2'd0, 16'o0060);
      wb_read(2'd2, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL up_wrap got %h want 0000", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0220) begin errors++; $display("FAIL up_done got %o want 0220", d); end
   endtask

   task automatic test_collision();
      logic [15:0] d;
      wb_write(2'd0, 16'o0);
      wb_read(2'd0, d);
      wb_write(2'd1, 16'd2);
      wb_write(2'd0, 16'o0001);
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0001) begin errors++; $display("FAIL col_read got %o want 0001", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0200) begin errors++; $display("FAIL col_kept got %o want 0200", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL col_clr got %o want 0", d); end
   endtask

   task automatic test_line_rate_ie_clear();
      logic [15:0] d;
      wb_write(2'd1, 16'd2);
      wb_write(2'd0, 16'o0105);
      wait_irq(4500);
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL lr_irq got %b want 1", irq_o); end
      wb_write(2'd0, 16'o0);
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL lr_ie_clr got %b want 0", irq_o); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0200) begin errors++; $display("FAIL lr_done got %o want 0200", d); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL lr_clr got %o want 0", d); end
   endtask

   task automatic test_ext();
      logic [15:0] d;
      logic [15:0] exp_ctr;
`ifdef KW11P_EXT_EN
      exp_ctr = 16'd2;
`else
      exp_ctr = 16'd5;
`endif
      wb_write(2'd1, 16'd5);
      wb_write(2'd0, 16'o0007);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_p); ext_tick = 1'b1;
         repeat (2) @(negedge clk_p);
         ext_tick = 1'b0;
         repeat (2) @(negedge clk_p);
      end
      wb_read(2'd2, d);
      checks++; if (d !== exp_ctr) begin errors++; $display("FAIL ext_ctr got %0d want %0d", d, exp_ctr); end
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0007) begin errors++; $display("FAIL ext_csr got %o want 0007", d); end
      wb_write(2'd0, 16'o0);
   endtask

   task automatic test_back_to_back();
      int acks;
      acks = 0;
      @(negedge clk_p);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd2;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_p); #1;
         if (wb_ack_o) acks++;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", acks); end
   endtask

   task automatic test_init();
      logic [15:0] d;
      wb_write(2'd1, 16'd7);
      wb_write(2'd0, 16'o0110);
      @(negedge clk_p); init = 1'b1;
      @(negedge clk_p); init = 1'b0;
      wb_read(2'd0, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL init_csr got %o want 0", d); end
      wb_read(2'd2, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL init_ctr got %o want 0", d); end
   endtask

   task automatic test_dclo_midcycle();
      logic [15:0] d;
      wb_write(2'd1, 16'd9);
      @(negedge clk_p);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
      @(posedge clk_p); #1;
      checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL dclo_pre_ack got %b want 1", wb_ack_o); end
      dclo = 1'b1; #1;
      checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL dclo_ack got %b want 0", wb_ack_o); end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge clk_p); dclo = 1'b0;
      wb_read(2'd2, d);
      checks++; if (d !== 16'o0) begin errors++; $display("FAIL dclo_ctr got %o want 0", d); end
   endtask

   initial begin
      test_reset();
      test_single_down();
      test_irq_handshake();
      test_fix();
      test_repeat();
      test_up_wrap();
      test_collision();
      test_line_rate_ie_clear();
      test_ext();
      test_back_to_back();
      test_init();
      test_dclo_midcycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
